sar_comparator_search: RTL

Successive-approximation search controller that drives the B operand of the team's 20-bit magnitude comparator (outputs Same, A_High, B_High) and uses its flags to recover an unknown A operand MSB-first. It is the driving end of the comparator interface: it produces B, consumes the three flags, and returns the recovered value through a start/done handshake. The comparator stays external and combinational. The block sits between a control FSM that needs A's value and the comparator pair.

---
 rtl/sar_search_pkg.sv | 22 ++
 rtl/sar_comparator_search.sv | 111 +++++++++++
 2 files changed

// File: rtl/sar_search_pkg.sv
// Shared types and helpers for the successive-approximation search controller.
// Holds the state encoding, the default operand width and the flag legality test.
package sar_search_pkg;

    localparam int SAR_WIDTH = 20;

    typedef enum logic [1:0] {
        IDLE,
        TRIAL,
        VERIFY,
        DONE
    } sar_state_e;

    function automatic logic flags_onehot(
        input logic same,
        input logic a_high,
        input logic b_high
    );
        return $onehot({same, a_high, b_high});
    endfunction

endpackage

// File: rtl/sar_comparator_search.sv
// SAR controller: drives comparator B and recovers operand A MSB-first.
// Optional SAR_EARLY_EXIT_EN: finish as soon as a trial matches A exactly.
module sar_comparator_search
    import sar_search_pkg::*;
#(
    parameter int WIDTH = SAR_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             Start,
    output logic [WIDTH-1:0] B,
    input  logic             Same,
    input  logic             A_High,
    input  logic             B_High,
    output logic             Busy,
    output logic             Done,
    output logic [WIDTH-1:0] Result,
    output logic             Found,
    output logic             Fault
);

    localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    sar_state_e       state_q, state_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             found_q, found_d;
    logic             fault_q, fault_d;
    logic             ok;
    logic             early;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            b_q      <= '0;
            idx_q    <= '0;
            result_q <= '0;
            found_q  <= 1'b0;
            fault_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            b_q      <= b_d;
            idx_q    <= idx_d;
            result_q <= result_d;
            found_q  <= found_d;
            fault_q  <= fault_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        b_d      = b_q;
        idx_d    = idx_q;
        result_d = result_q;
        found_d  = found_q;
        fault_d  = fault_q;
        ok       = flags_onehot(Same, A_High, B_High);
        early    = 1'b0;
`ifdef SAR_EARLY_EXIT_EN
        early    = ok && Same;
`endif
        unique case (state_q)
            IDLE: begin
                if (Start) begin
                    b_d            = '0;
                    b_d[WIDTH-1]   = 1'b1;
                    idx_d          = IW'(WIDTH - 1);
                    fault_d        = 1'b0;
                    state_d        = TRIAL;
                end
            end
            TRIAL: begin
                if (!ok) fault_d = 1'b1;
                if (early) begin
                    result_d = b_q;
                    found_d  = 1'b1;
                    state_d  = DONE;
                end else begin
                    // an illegal flag vector keeps the trial bit
                    if (ok && B_High) b_d[idx_q] = 1'b0;
                    if (idx_q != '0) begin
                        b_d[idx_q - 1'b1] = 1'b1;
                        idx_d             = idx_q - 1'b1;
                    end else begin
                        state_d = VERIFY;
                    end
                end
            end
            VERIFY: begin
                if (!ok) fault_d = 1'b1;
                found_d  = Same;
                result_d = b_q;
                state_d  = DONE;
            end
            DONE: begin
                b_d     = '0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign B      = b_q;
    assign Busy   = (state_q == TRIAL) || (state_q == VERIFY);
    assign Done   = (state_q == DONE);
    assign Result = result_q;
    assign Found  = found_q;
    assign Fault  = fault_q;

endmodule
